// File: rtl/lcd_char_writer.sv
// HD44780 8-bit write controller: runs the power-up init sequence, then writes
// one character per request as set-DDRAM-address followed by a data write.
module lcd_char_writer #(
    parameter int EN_PULSE  = 25,
    parameter int CHAR_WAIT = 2500,
    parameter int CMD_WAIT  = 100000,
    parameter int INIT_WAIT = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] CHAR_IN,
    input  logic       CHAR_VALID,
    input  logic [4:0] POS,
    input  logic       CLR_REQ,
    output logic       READY,
    output logic       INIT_DONE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic [2:0] dbg_state,
    output logic [1:0] dbg_phase
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(EN_PULSE, CHAR_WAIT), max2(CMD_WAIT, INIT_WAIT));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_PULSE - 1);
    localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_WAIT - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT - 1);

    typedef enum logic [2:0] {
        S_INIT_DLY = 3'd0,
        S_INIT_CMD = 3'd1,
        S_IDLE     = 3'd2,
        S_WR_ADDR  = 3'd3,
        S_WR_CHAR  = 3'd4,
        S_WR_CLR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP = 2'd0,
        P_E_HI  = 2'd1,
        P_HOLD  = 2'd2,
        P_WAIT  = 2'd3
    } phase_t;

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       step, step_n;
    logic [7:0]       char_q, char_n;
    logic [4:0]       pos_q, pos_n;
    logic             init_done, init_done_n;

    logic [7:0]       bus_byte;
    logic             in_write;
    logic             long_wait;
    logic [CNT_W-1:0] wait_last;

    // Handshake: a request (CLR_REQ or CHAR_VALID) is taken on a rising edge
    // where READY=1; CLR_REQ has priority and a coincident CHAR_VALID is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_INIT_DLY;
            phase     <= P_SETUP;
            cnt       <= '0;
            step      <= 2'd0;
            char_q    <= 8'h00;
            pos_q     <= 5'd0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            cnt       <= cnt_n;
            step      <= step_n;
            char_q    <= char_n;
            pos_q     <= pos_n;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        bus_byte = 8'h00;
        case (state)
            S_INIT_CMD: begin
                case (step)
                    2'd0:    bus_byte = 8'h38;
                    2'd1:    bus_byte = 8'h0C;
                    2'd2:    bus_byte = 8'h06;
                    default: bus_byte = 8'h01;
                endcase
            end
            S_WR_ADDR: bus_byte = {1'b1, pos_q[4], 2'b00, pos_q[3:0]};
            // the decoder's null byte shows as a blank cell
            S_WR_CHAR: bus_byte = (char_q == 8'h00) ? 8'h20 : char_q;
            S_WR_CLR:  bus_byte = 8'h01;
            default:   bus_byte = 8'h00;
        endcase
    end

    assign in_write  = (state == S_INIT_CMD) || (state == S_WR_ADDR) ||
                       (state == S_WR_CHAR)  || (state == S_WR_CLR);
    assign long_wait = (state == S_WR_CLR) || ((state == S_INIT_CMD) && (step == 2'd3));
    assign wait_last = long_wait ? CMD_LAST : CHAR_LAST;

    always_comb begin
        state_n     = state;
        phase_n     = phase;
        cnt_n       = cnt;
        step_n      = step;
        char_n      = char_q;
        pos_n       = pos_q;
        init_done_n = init_done;

        case (state)
            S_INIT_DLY: begin
                if (cnt == INIT_LAST) begin
                    state_n = S_INIT_CMD;
                    phase_n = P_SETUP;
                    cnt_n   = '0;
                    step_n  = 2'd0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (CLR_REQ) begin
                    state_n = S_WR_CLR;
                    phase_n = P_SETUP;
                    cnt_n   = '0;
                end else if (CHAR_VALID) begin
                    state_n = S_WR_ADDR;
                    phase_n = P_SETUP;
                    cnt_n   = '0;
                    char_n  = CHAR_IN;
                    pos_n   = POS;
                end
            end
            default: begin
                case (phase)
                    P_SETUP: begin
                        phase_n = P_E_HI;
                        cnt_n   = '0;
                    end
                    P_E_HI: begin
                        if (cnt == EN_LAST) begin
                            phase_n = P_HOLD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                    P_HOLD: begin
                        phase_n = P_WAIT;
                        cnt_n   = '0;
                    end
                    default: begin
                        if (cnt == wait_last) begin
                            phase_n = P_SETUP;
                            cnt_n   = '0;
                            case (state)
                                S_INIT_CMD: begin
                                    if (step == 2'd3) begin
                                        state_n     = S_IDLE;
                                        init_done_n = 1'b1;
                                    end else begin
                                        step_n = step + 2'd1;
                                    end
                                end
                                S_WR_ADDR: state_n = S_WR_CHAR;
                                default:   state_n = S_IDLE;
                            endcase
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        endcase
    end

    assign READY     = (state == S_IDLE);
    assign INIT_DONE = init_done;
    assign LCD_E     = in_write && (phase == P_E_HI);
    assign LCD_RS    = (state == S_WR_CHAR);
    assign LCD_RW    = 1'b0;
    assign LCD_DATA  = bus_byte;
    assign dbg_state = state;
    assign dbg_phase = phase;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: directed requests, scoreboard of expected bus
// writes {RS, DATA} checked by a monitor on every LCD_E rising edge.
module tb_lcd_char_writer;

    localparam int EN_PULSE  = 2;
    localparam int CHAR_WAIT = 4;
    localparam int CMD_WAIT  = 10;
    localparam int INIT_WAIT = 20;

    logic       CLK;
    logic       RST;
    logic [7:0] CHAR_IN;
    logic       CHAR_VALID;
    logic [4:0] POS;
    logic       CLR_REQ;
    logic       READY;
    logic       INIT_DONE;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic [2:0] dbg_state;
    logic [1:0] dbg_phase;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q[$];
    logic       rst_abort = 1'b0;

    lcd_char_writer #(
        .EN_PULSE (EN_PULSE),
        .CHAR_WAIT(CHAR_WAIT),
        .CMD_WAIT (CMD_WAIT),
        .INIT_WAIT(INIT_WAIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CHAR_IN   (CHAR_IN),
        .CHAR_VALID(CHAR_VALID),
        .POS       (POS),
        .CLR_REQ   (CLR_REQ),
        .READY     (READY),
        .INIT_DONE (INIT_DONE),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA),
        .dbg_state (dbg_state),
        .dbg_phase (dbg_phase)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one pop per enable pulse, plus pulse-width and hold checks
    initial begin
        logic       prev_e;
        logic [8:0] cap;
        logic [8:0] exp;
        int         width;
        prev_e = 1'b0;
        cap    = '0;
        width  = 0;
        forever begin
            @(negedge CLK);
            if (LCD_E && !prev_e) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write at %0t",
                             {LCD_RS, LCD_DATA}, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("bus_write", 32'({LCD_RS, LCD_DATA}), 32'(exp));
                end
                check("lcd_rw", 32'(LCD_RW), 32'd0);
                cap   = {LCD_RS, LCD_DATA};
                width = 1;
            end else if (LCD_E) begin
                width++;
                check("bus_stable_e_hi", 32'({LCD_RS, LCD_DATA}), 32'(cap));
            end else if (prev_e && !rst_abort) begin
                check("e_width", 32'(width), 32'(EN_PULSE));
                check("bus_stable_hold", 32'({LCD_RS, LCD_DATA}), 32'(cap));
            end
            prev_e = LCD_E;
        end
    end

    // driver tasks
    task automatic check_reset_values();
        check("rst_e", 32'(LCD_E), 32'd0);
        check("rst_rs", 32'(LCD_RS), 32'd0);
        check("rst_rw", 32'(LCD_RW), 32'd0);
        check("rst_data", 32'(LCD_DATA), 32'h00);
        check("rst_ready", 32'(READY), 32'd0);
        check("rst_init_done", 32'(INIT_DONE), 32'd0);
    endtask

    // Called at a negedge after an edge that sampled RST=1.
    task automatic run_init();
        logic e_quiet;
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        RST     = 1'b0;
        e_quiet = 1'b1;
        for (int i = 1; i <= 57; i++) begin
            @(negedge CLK);
            if (i <= 20 && LCD_E) e_quiet = 1'b0;
            if (i == 57) check("init_ready_early", 32'(READY), 32'd0);
        end
        check("init_delay_e_low", 32'(e_quiet), 32'd1);
        @(negedge CLK);
        check("init_ready", 32'(READY), 32'd1);
        check("init_done", 32'(INIT_DONE), 32'd1);
    endtask

    // Called at the negedge just after the accept edge.
    task automatic measure_busy(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (!READY && n < 200) begin
            n++;
            @(negedge CLK);
        end
        check(name, 32'(n), 32'(exp_cycles));
    endtask

    task automatic send_char(input logic [7:0] c, input logic [4:0] p,
                             input logic [8:0] exp_addr, input logic [8:0] exp_data);
        int n;
        n = 0;
        while (!READY && n < 200) begin
            n++;
            @(negedge CLK);
        end
        CHAR_IN    = c;
        POS        = p;
        CHAR_VALID = 1'b1;
        exp_q.push_back(exp_addr);
        exp_q.push_back(exp_data);
        @(negedge CLK);
        CHAR_VALID = 1'b0;
        CHAR_IN    = ~c;
        POS        = ~p;
        measure_busy("char_busy", 16);
    endtask

    // stimulus
    initial begin
        int n;
        RST        = 1'b1;
        CHAR_IN    = 8'h00;
        CHAR_VALID = 1'b0;
        POS        = 5'd0;
        CLR_REQ    = 1'b0;

        repeat (3) @(negedge CLK);
        check_reset_values();
        run_init();

        // row 1, column 3
        send_char(8'h35, 5'b1_0011, 9'h0C3, 9'h135);
        // null byte at row 0 col 0 becomes a space
        send_char(8'h00, 5'b0_0000, 9'h080, 9'h120);
        send_char(8'h7A, 5'b0_1111, 9'h08F, 9'h17A);

        // clear wins over a coincident character request
        CLR_REQ    = 1'b1;
        CHAR_VALID = 1'b1;
        CHAR_IN    = 8'h39;
        POS        = 5'b1_0101;
        exp_q.push_back(9'h001);
        @(negedge CLK);
        CLR_REQ    = 1'b0;
        CHAR_VALID = 1'b0;
        measure_busy("clr_busy", 14);

        // held CHAR_VALID: one transaction, then the next request taken at first READY
        CHAR_IN    = 8'h41;
        POS        = 5'b0_0001;
        CHAR_VALID = 1'b1;
        exp_q.push_back(9'h081);
        exp_q.push_back(9'h141);
        @(negedge CLK);
        CHAR_IN = 8'h42;
        POS     = 5'b1_0010;
        exp_q.push_back(9'h0C2);
        exp_q.push_back(9'h142);
        measure_busy("held_busy_1", 16);
        @(negedge CLK);
        CHAR_VALID = 1'b0;
        measure_busy("held_busy_2", 16);
        repeat (30) @(negedge CLK);
        check("idle_queue_drained", 32'(exp_q.size()), 32'd0);

        // reset during E_HI of a data write
        CHAR_IN    = 8'h55;
        POS        = 5'b0_0000;
        CHAR_VALID = 1'b1;
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h155);
        @(negedge CLK);
        CHAR_VALID = 1'b0;
        rst_abort  = 1'b1;
        n = 0;
        while (!(LCD_E && LCD_RS) && n < 100) begin
            n++;
            @(negedge CLK);
        end
        check("reach_data_e_hi", 32'(LCD_E && LCD_RS), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_values();
        check("rst_state", 32'(dbg_state), 32'd0);
        run_init();
        rst_abort = 1'b0;

        send_char(8'h36, 5'b1_0000, 9'h0C0, 9'h136);
        repeat (10) @(negedge CLK);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lcd_char_writer.md
# lcd_char_writer

Sequential HD44780-compatible character-LCD write controller sitting directly downstream of the BCD-to-ASCII digit decoder. It accepts one ASCII byte plus a screen position per handshake, then drives the 8-bit LCD bus with the set-DDRAM-address command followed by the data write. All enable-pulse and execution-wait timing is generated from the single system clock. After reset it runs the LCD power-up initialisation sequence on its own.

## Interface
Parameters:
- EN_PULSE, 25: cycles LCD_E is held high per bus write (≥450 ns at 50 MHz).
- CHAR_WAIT, 2500: wait cycles after a normal command or data write (≥40 µs).
- CMD_WAIT, 100000: wait cycles after a clear-display command (≥1.64 ms).
- INIT_WAIT, 1000000: power-up delay cycles before the first command (≥15 ms).

Ports:
- CLK  input  1  system clock; everything is on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- CHAR_IN  input  8  ASCII byte from the decoder.
- CHAR_VALID  input  1  request to write CHAR_IN at POS.
- POS  input  5  bit 4 is the row (0/1), bits 3:0 are the column (0–15).
- CLR_REQ  input  1  request to clear the display.
- READY  output  1  block idle; a request is accepted in this cycle.
- INIT_DONE  output  1  initialisation complete (sticky until RST).
- LCD_E  output  1  LCD enable strobe.
- LCD_RS  output  1  0 = command, 1 = data.
- LCD_RW  output  1  tied to 0 (write only).
- LCD_DATA  output  8  LCD data bus.

## Operation
- States: INIT_DLY, INIT_CMD (4 steps), IDLE, WR_ADDR, WR_CHAR, WR_CLR. Every write uses the bus sub-sequence SETUP → E_HI → HOLD → WAIT.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, READY=0, INIT_DONE=0. State is INIT_DLY and all counters are cleared.
- Initialisation:
  - Wait INIT_WAIT cycles.
  - Issue commands 8'h38, 8'h0C, 8'h06 (each followed by CHAR_WAIT), then 8'h01 (followed by CMD_WAIT).
  - Then enter IDLE and set INIT_DONE=1.
- IDLE: READY=1. Requests are ignored unless READY=1.
- Character request (CHAR_VALID & READY):
  - Latch CHAR_IN and POS.
  - Write command 8'h80 | {1'b0, POS[4], 2'b00, POS[3:0]}, i.e. row 0 maps to 8'h80+col and row 1 to 8'hC0+col.
  - Then write data with LCD_RS=1.
  - A latched byte of 8'h00 (decoder null) is written as 8'h20 (space).
- Clear request (CLR_REQ & READY): write command 8'h01, followed by CMD_WAIT.
- Simultaneous CLR_REQ and CHAR_VALID: CLR_REQ wins and CHAR_VALID is dropped; the upstream block must re-present it.
- Inputs changing after acceptance have no effect; only the latched values are used.
- RST asserted mid-transaction: on the next edge LCD_E=0, all outputs return to their reset values, and initialisation restarts from INIT_DLY.

## Timing
- One bus write is 1 SETUP cycle (RS/DATA valid, E=0), then EN_PULSE cycles with E=1, then 1 HOLD cycle (E=0, DATA/RS held), then W wait cycles. Total: EN_PULSE+2+W cycles.
- LCD_DATA and LCD_RS are stable throughout SETUP, E_HI and HOLD.
- READY falls in the cycle after acceptance.
- Character write: READY returns high exactly 2·(EN_PULSE+CHAR_WAIT+2) cycles after the accept edge.
- Clear: READY returns high EN_PULSE+CMD_WAIT+2 cycles after the accept edge.
- Init: INIT_DONE and READY rise together INIT_WAIT + 3·(EN_PULSE+CHAR_WAIT+2) + (EN_PULSE+CMD_WAIT+2) cycles after RST deasserts.
- Wait counters must be sized for the largest parameter; no wrap-around is permitted.

## Test plan
All scenarios use EN_PULSE=2, CHAR_WAIT=4, CMD_WAIT=10, INIT_WAIT=20.
- Reset release → 20 idle cycles with E=0, then bus writes 38, 0C, 06 (RS=0, 2-cycle E pulses), then 01. INIT_DONE=READY=1 at cycle 20+3·8+14=58.
- CHAR_IN=8'h35, POS=5'b1_0011, one-cycle CHAR_VALID → command C3 (RS=0) then data 35 (RS=1). READY is low for exactly 16 cycles.
- CHAR_IN=8'h00, POS=0 → command 80, then data 20.
- CLR_REQ and CHAR_VALID asserted in the same cycle → only command 01 is seen. READY returns after 14 cycles; no data write occurs.
- CHAR_VALID held high while READY=0 → no extra transaction. A second character is accepted only in the first cycle READY=1.
- RST pulsed during the E_HI phase of a data write → LCD_E=0 on the next edge, outputs return to reset values, and the init sequence repeats.
